// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet MAC datapath: framer states and
// the fixed byte values and CRC-32 constants used on the wire.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_HDR,
        ST_PAY,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } eth_state_t;

    localparam logic [7:0]  PREAMBLE = 8'h55;
    localparam logic [7:0]  SFD      = 8'hD5;
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam int          HDR_LEN  = 14;
    localparam int          PRE_LEN  = 7;
    localparam int          FCS_LEN  = 4;

endpackage

// File: rtl/eth_crc32_d8.sv
// Byte-wide combinational step of the reflected Ethernet CRC-32.
// The data byte is consumed LSB first, matching the bit order on the wire,
// so the same block can serve the receive-side checker.
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_cur,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    logic [31:0] acc;

    // Fold the byte into the low bits, then shift out eight bits through the polynomial
    always_comb begin
        acc = crc_cur ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            if (acc[0]) begin
                acc = (acc >> 1) ^ CRC_POLY;
            end else begin
                acc = acc >> 1;
            end
        end
        crc_next = acc;
    end

endmodule

// File: rtl/eth_mac_tx.sv
// Ethernet MAC transmit framer: wraps an upstream payload stream into a
// complete frame (preamble, SFD, header, payload, pad, FCS) and enforces
// the inter-frame gap. Underrun and oversize abort the frame with a
// deliberately corrupted FCS so the far end drops it.
module eth_mac_tx
    import eth_pkg::*;
#(
    parameter logic [47:0] P_SRC_MAC     = 48'h00_0A_35_01_FE_C0,
    parameter int          P_MIN_PAYLOAD = 46,
    parameter int          P_MAX_PAYLOAD = 1500,
    parameter int          P_IFG_BYTES   = 12
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [47:0] i_dst_mac,
    input  logic [15:0] i_eth_type,
    input  logic [7:0]  i_pay_data,
    input  logic        i_pay_valid,
    input  logic        i_pay_last,
    output logic        o_pay_ready,
    output logic [7:0]  o_send_data,
    output logic        o_send_valid,
    output logic        o_busy,
    output logic        o_err
);

    localparam logic [10:0] MIN_CNT = 11'(P_MIN_PAYLOAD);
    localparam logic [10:0] MAX_CNT = 11'(P_MAX_PAYLOAD);

    eth_state_t  state;
    eth_state_t  state_next;
    logic [15:0] step;
    logic [10:0] pay_cnt;
    logic [10:0] pay_cnt_inc;
    logic [47:0] dst_mac;
    logic [15:0] eth_type;
    logic [31:0] crc;
    logic [31:0] crc_calc;
    logic        bad_fcs;

    logic [111:0] hdr_vec;
    logic [111:0] hdr_shift;
    logic [7:0]   hdr_byte;
    logic         fcs_bad_sel;
    logic [1:0]   fcs_idx;
    logic [31:0]  fcs_word;
    logic [31:0]  fcs_shift;
    logic [7:0]   fcs_byte;

    logic [7:0] byte_next;
    logic       valid_next;
    logic       err_next;
    logic       crc_en;
    logic       underrun;
    logic       oversize;

    // Saturating increment keeps the payload count from wrapping on long streams
    assign pay_cnt_inc = (pay_cnt == 11'h7FF) ? pay_cnt : pay_cnt + 11'd1;

    assign underrun = (state == ST_PAY) && !i_pay_valid;
    assign oversize = (state == ST_PAY) && i_pay_valid && !i_pay_last && (pay_cnt_inc >= MAX_CNT);

    // Header is shifted left so the current byte always sits in the top eight bits
    assign hdr_vec   = {dst_mac, P_SRC_MAC, eth_type};
    assign hdr_shift = hdr_vec << {step[3:0], 3'b000};
    assign hdr_byte  = hdr_shift[111:104];

    // An underrun emits FCS byte 0 in the PAY cycle itself so o_send_valid has no hole
    assign fcs_bad_sel = (state == ST_PAY) ? 1'b1 : bad_fcs;
    assign fcs_idx     = (state == ST_PAY) ? 2'd0 : step[1:0];
    assign fcs_word    = fcs_bad_sel ? crc : ~crc;
    assign fcs_shift   = fcs_word >> {fcs_idx, 3'b000};
    assign fcs_byte    = fcs_shift[7:0];

    assign o_pay_ready = (state == ST_PAY);
    assign o_busy      = (state != ST_IDLE);

    eth_crc32_d8 u_crc (
        .crc_cur  (crc),
        .data     (byte_next),
        .crc_next (crc_calc)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decision for each phase of the frame
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (i_pay_valid) state_next = ST_PRE;
            ST_PRE:  if (step == 16'(PRE_LEN - 1)) state_next = ST_SFD;
            ST_SFD:  state_next = ST_HDR;
            ST_HDR:  if (step == 16'(HDR_LEN - 1)) state_next = ST_PAY;
            ST_PAY: begin
                if (!i_pay_valid) begin
                    state_next = ST_FCS;
                end else if (i_pay_last) begin
                    state_next = (pay_cnt_inc < MIN_CNT) ? ST_PAD : ST_FCS;
                end else if (pay_cnt_inc >= MAX_CNT) begin
                    state_next = ST_FCS;
                end
            end
            ST_PAD:  if (pay_cnt_inc >= MIN_CNT) state_next = ST_FCS;
            ST_FCS:  if (step == 16'(FCS_LEN - 1)) state_next = ST_IFG;
            ST_IFG:  if (step == 16'(P_IFG_BYTES - 1)) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Byte to emit next cycle, whether it feeds the CRC, and error pulses
    always_comb begin
        byte_next  = 8'h00;
        valid_next = 1'b0;
        err_next   = 1'b0;
        crc_en     = 1'b0;
        case (state)
            ST_PRE: begin
                valid_next = 1'b1;
                byte_next  = PREAMBLE;
            end
            ST_SFD: begin
                valid_next = 1'b1;
                byte_next  = SFD;
            end
            ST_HDR: begin
                valid_next = 1'b1;
                byte_next  = hdr_byte;
                crc_en     = 1'b1;
            end
            ST_PAY: begin
                valid_next = 1'b1;
                if (i_pay_valid) begin
                    byte_next = i_pay_data;
                    crc_en    = 1'b1;
                    err_next  = oversize;
                end else begin
                    byte_next = fcs_byte;
                    err_next  = 1'b1;
                end
            end
            ST_PAD: begin
                valid_next = 1'b1;
                crc_en     = 1'b1;
            end
            ST_FCS: begin
                valid_next = 1'b1;
                byte_next  = fcs_byte;
            end
            default: ;
        endcase
    end

    // Step counter restarts on each state change; underrun already sent FCS byte 0
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            step <= '0;
        end else if (state_next != state) begin
            step <= underrun ? 16'd1 : 16'd0;
        end else if (state != ST_IDLE) begin
            step <= step + 16'd1;
        end
    end

    // Frame context: latched addressing, payload count, running CRC and abort flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dst_mac  <= '0;
            eth_type <= '0;
            pay_cnt  <= '0;
            crc      <= CRC_INIT;
            bad_fcs  <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                pay_cnt <= '0;
                bad_fcs <= 1'b0;
                if (i_pay_valid) begin
                    dst_mac  <= i_dst_mac;
                    eth_type <= i_eth_type;
                end
            end else if ((state == ST_PAY && i_pay_valid) || state == ST_PAD) begin
                pay_cnt <= pay_cnt_inc;
            end
            if (underrun || oversize) begin
                bad_fcs <= 1'b1;
            end
            if (state == ST_SFD) begin
                crc <= CRC_INIT;
            end else if (crc_en) begin
                crc <= crc_calc;
            end
        end
    end

    // Registered transmit outputs, one cycle behind the generating state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_send_data  <= 8'h00;
            o_send_valid <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_send_data  <= byte_next;
            o_send_valid <= valid_next;
            o_err        <= err_next;
        end
    end

endmodule

// File: tb/tb_eth_mac_tx.sv
// Self-checking bench for eth_mac_tx: randomized payload frames compared
// against a byte-level frame model, plus standalone CRC and abort scenarios.
module tb_eth_mac_tx;
    import eth_pkg::*;

    localparam logic [47:0] SRC_MAC = 48'h000A3501FEC0;
    localparam int MIN_PAY = 46;
    localparam int IFG     = 12;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [47:0] i_dst_mac = '0;
    logic [15:0] i_eth_type = '0;
    logic [7:0]  i_pay_data = '0;
    logic        i_pay_valid = 1'b0;
    logic        i_pay_last = 1'b0;
    logic        o_pay_ready;
    logic [7:0]  o_send_data;
    logic        o_send_valid;
    logic        o_busy;
    logic        o_err;

    logic [31:0] tcrc;
    logic [31:0] tnext;
    logic [7:0]  tdat;

    logic [7:0] pay [0:1599];
    logic [7:0] cap [$];
    logic [7:0] exp_q [$];
    int  rises = 0;
    int  zero_run = 0;
    int  last_gap = 0;
    int  err_cnt = 0;
    bit  prev_valid = 1'b0;
    int  n_vec = 0;
    int  n_fail = 0;

    eth_mac_tx dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_dst_mac    (i_dst_mac),
        .i_eth_type   (i_eth_type),
        .i_pay_data   (i_pay_data),
        .i_pay_valid  (i_pay_valid),
        .i_pay_last   (i_pay_last),
        .o_pay_ready  (o_pay_ready),
        .o_send_data  (o_send_data),
        .o_send_valid (o_send_valid),
        .o_busy       (o_busy),
        .o_err        (o_err)
    );

    eth_crc32_d8 u_crc_unit (
        .crc_cur  (tcrc),
        .data     (tdat),
        .crc_next (tnext)
    );

    always #4 i_clk = ~i_clk;

    // Capture the transmitted stream and track valid runs, gaps and error pulses
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            prev_valid = 1'b0;
            zero_run   = 0;
        end else begin
            if (o_send_valid) begin
                cap.push_back(o_send_data);
                if (!prev_valid) begin
                    rises++;
                    last_gap = zero_run;
                end
                zero_run = 0;
            end else begin
                zero_run++;
            end
            if (o_err) err_cnt++;
            prev_valid = o_send_valid;
        end
    end

    // Bit-serial reference CRC step, LSB of the byte first
    function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    // Append the expected wire bytes of one frame built from pay[0..n-1]
    task automatic build_expected(input logic [47:0] dst, input logic [15:0] typ,
                                  input int n, input bit bad);
        logic [7:0]   body [$];
        logic [111:0] h;
        logic [31:0]  c;
        logic [31:0]  fcs;
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        h = {dst, SRC_MAC, typ};
        for (int i = 0; i < 14; i++) body.push_back(h[111 - 8*i -: 8]);
        for (int i = 0; i < n; i++) body.push_back(pay[i]);
        if (!bad) begin
            for (int i = n; i < MIN_PAY; i++) body.push_back(8'h00);
        end
        c = 32'hFFFFFFFF;
        foreach (body[i]) c = crc_model(c, body[i]);
        fcs = bad ? c : ~c;
        foreach (body[i]) exp_q.push_back(body[i]);
        for (int i = 0; i < 4; i++) exp_q.push_back(fcs[8*i +: 8]);
    endtask

    function automatic int first_diff();
        for (int i = 0; i < cap.size() && i < exp_q.size(); i++) begin
            if (cap[i] !== exp_q[i]) return i;
        end
        return -1;
    endfunction

    task automatic start_frame(input logic [47:0] dst, input logic [15:0] typ);
        i_dst_mac  = dst;
        i_eth_type = typ;
        cap.delete();
        exp_q.delete();
        rises   = 0;
        err_cnt = 0;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) pay[i] = 8'($urandom());
    endtask

    // Offer pay[0..stop-1]; last on byte n_last; give up after 10 refused cycles mid-payload
    task automatic drive(input int stop, input int n_last, output int accepted);
        int idx;
        int stall;
        int guard;
        idx = 0; stall = 0; guard = 0;
        while (idx < stop && stall < 10 && guard < 4000) begin
            @(negedge i_clk);
            i_pay_valid = 1'b1;
            i_pay_data  = pay[idx];
            i_pay_last  = (idx == n_last - 1);
            if (o_pay_ready) begin
                idx++;
                stall = 0;
            end else if (idx > 0) begin
                stall++;
            end
            guard++;
        end
        @(negedge i_clk);
        i_pay_valid = 1'b0;
        i_pay_last  = 1'b0;
        accepted = idx;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge i_clk);
            if (!o_busy) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge i_clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge i_clk);
        i_pay_valid = 1'b1;
        @(negedge i_clk);
        n_vec++; if (o_send_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %0b expected 0", o_send_valid); end
        n_vec++; if (o_send_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_data: got %02h expected 00", o_send_data); end
        n_vec++; if (o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %0b expected 0", o_busy); end
        n_vec++; if (o_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %0b expected 0", o_err); end
        n_vec++; if (o_pay_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready: got %0b expected 0", o_pay_ready); end
        i_pay_valid = 1'b0;
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        n_vec++; if (o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_busy: got %0b expected 0", o_busy); end
    endtask

    task automatic test_crc_unit();
        string s;
        s = "123456789";
        tcrc = 32'hFFFFFFFF;
        for (int i = 0; i < s.len(); i++) begin
            tdat = s[i];
            #1;
            tcrc = tnext;
        end
        n_vec++; if (~tcrc !== 32'hCBF43926) begin n_fail++; $display("[TB] FAIL crc_check: got %08h expected cbf43926", ~tcrc); end
        for (int i = 0; i < 8; i++) begin
            tcrc = $urandom();
            tdat = 8'($urandom());
            #1;
            n_vec++; if (tnext !== crc_model(tcrc, tdat)) begin n_fail++; $display("[TB] FAIL crc_step: got %08h expected %08h", tnext, crc_model(tcrc, tdat)); end
        end
    endtask

    task automatic test_short_frame();
        int acc;
        bit ok;
        for (int i = 0; i < 10; i++) pay[i] = 8'(i + 1);
        start_frame(48'hFFFF_FFFF_FFFF, 16'h0800);
        drive(10, 10, acc);
        wait_idle(ok);
        build_expected(48'hFFFF_FFFF_FFFF, 16'h0800, 10, 1'b0);
        n_vec++; if (!ok) begin n_fail++; $display("[TB] FAIL short_timeout: got busy expected idle"); end
        n_vec++; if (acc != 10) begin n_fail++; $display("[TB] FAIL short_accepted: got %0d expected 10", acc); end
        n_vec++; if (cap.size() != 72) begin n_fail++; $display("[TB] FAIL short_len: got %0d expected 72", cap.size()); end
        n_vec++; if (first_diff() >= 0) begin n_fail++; $display("[TB] FAIL short_bytes: index %0d got %02h expected %02h", first_diff(), cap[first_diff()], exp_q[first_diff()]); end
        n_vec++; if (rises != 1) begin n_fail++; $display("[TB] FAIL short_contiguous: got %0d runs expected 1", rises); end
        n_vec++; if (err_cnt != 0) begin n_fail++; $display("[TB] FAIL short_err: got %0d expected 0", err_cnt); end
        n_vec++; if (zero_run < IFG) begin n_fail++; $display("[TB] FAIL short_ifg: got %0d idle expected >= %0d", zero_run, IFG); end
    endtask

    task automatic test_random_frames();
        int lens [6];
        int acc;
        int n;
        bit ok;
        logic [47:0] dst;
        logic [15:0] typ;
        lens = '{1, 45, 46, 47, 0, 0};
        foreach (lens[k]) begin
            n = (lens[k] == 0) ? int'($urandom_range(1, 120)) : lens[k];
            dst[47:16] = $urandom();
            dst[15:0]  = 16'($urandom());
            typ        = 16'($urandom());
            fill_random(n);
            start_frame(dst, typ);
            drive(n, n, acc);
            wait_idle(ok);
            build_expected(dst, typ, n, 1'b0);
            n_vec++; if (!ok || acc != n) begin n_fail++; $display("[TB] FAIL rand_accept: got %0d expected %0d", acc, n); end
            n_vec++; if (cap.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL rand_len: got %0d expected %0d", cap.size(), exp_q.size()); end
            n_vec++; if (first_diff() >= 0) begin n_fail++; $display("[TB] FAIL rand_bytes: len %0d index %0d got %02h expected %02h", n, first_diff(), cap[first_diff()], exp_q[first_diff()]); end
            n_vec++; if (rises != 1 || err_cnt != 0) begin n_fail++; $display("[TB] FAIL rand_flags: got runs %0d err %0d expected 1 and 0", rises, err_cnt); end
        end
    endtask

    task automatic test_max_frame();
        int acc;
        bit ok;
        fill_random(1500);
        start_frame(48'h0102_0304_0506, 16'h86DD);
        drive(1500, 1500, acc);
        wait_idle(ok);
        build_expected(48'h0102_0304_0506, 16'h86DD, 1500, 1'b0);
        n_vec++; if (!ok || acc != 1500) begin n_fail++; $display("[TB] FAIL max_accept: got %0d expected 1500", acc); end
        n_vec++; if (cap.size() != 1526) begin n_fail++; $display("[TB] FAIL max_len: got %0d expected 1526", cap.size()); end
        n_vec++; if (first_diff() >= 0) begin n_fail++; $display("[TB] FAIL max_bytes: index %0d got %02h expected %02h", first_diff(), cap[first_diff()], exp_q[first_diff()]); end
        n_vec++; if (err_cnt != 0 || rises != 1) begin n_fail++; $display("[TB] FAIL max_flags: got err %0d runs %0d expected 0 and 1", err_cnt, rises); end
    endtask

    task automatic test_underrun();
        int acc;
        bit ok;
        fill_random(20);
        start_frame(48'hA0B1_C2D3_E4F5, 16'h0806);
        drive(20, 0, acc);
        wait_idle(ok);
        build_expected(48'hA0B1_C2D3_E4F5, 16'h0806, 20, 1'b1);
        n_vec++; if (!ok || acc != 20) begin n_fail++; $display("[TB] FAIL under_accept: got %0d expected 20", acc); end
        n_vec++; if (cap.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL under_len: got %0d expected %0d", cap.size(), exp_q.size()); end
        n_vec++; if (first_diff() >= 0) begin n_fail++; $display("[TB] FAIL under_bytes: index %0d got %02h expected %02h", first_diff(), cap[first_diff()], exp_q[first_diff()]); end
        n_vec++; if (err_cnt != 1) begin n_fail++; $display("[TB] FAIL under_err: got %0d pulses expected 1", err_cnt); end
        n_vec++; if (rises != 1) begin n_fail++; $display("[TB] FAIL under_contiguous: got %0d runs expected 1", rises); end
    endtask

    task automatic test_oversize();
        int acc;
        bit ok;
        bit ready_seen;
        fill_random(1600);
        start_frame(48'h1122_3344_5566, 16'h0800);
        drive(1600, 0, acc);
        ready_seen = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge i_clk);
            if (o_pay_ready) ready_seen = 1'b1;
            if (!o_busy) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge i_clk);
        build_expected(48'h1122_3344_5566, 16'h0800, 1500, 1'b1);
        n_vec++; if (acc != 1500) begin n_fail++; $display("[TB] FAIL over_accept: got %0d expected 1500", acc); end
        n_vec++; if (!ok) begin n_fail++; $display("[TB] FAIL over_timeout: got busy expected idle"); end
        n_vec++; if (ready_seen) begin n_fail++; $display("[TB] FAIL over_ready: got 1 expected 0 until next frame"); end
        n_vec++; if (err_cnt != 1) begin n_fail++; $display("[TB] FAIL over_err: got %0d pulses expected 1", err_cnt); end
        n_vec++; if (cap.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL over_len: got %0d expected %0d", cap.size(), exp_q.size()); end
        n_vec++; if (first_diff() >= 0) begin n_fail++; $display("[TB] FAIL over_bytes: index %0d got %02h expected %02h", first_diff(), cap[first_diff()], exp_q[first_diff()]); end
    endtask

    task automatic test_reset_mid_frame();
        int acc;
        bit ok;
        bit reached;
        fill_random(10);
        start_frame(48'hFFFF_FFFF_FFFF, 16'h0800);
        @(negedge i_clk);
        i_pay_valid = 1'b1;
        i_pay_data  = pay[0];
        reached = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge i_clk);
            if (cap.size() >= 12) begin
                reached = 1'b1;
                break;
            end
        end
        i_rst_n = 1'b0;
        #1;
        n_vec++; if (!reached) begin n_fail++; $display("[TB] FAIL rst_reach_hdr: got %0d bytes expected 12", cap.size()); end
        n_vec++; if (o_send_valid !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid: got valid %0b busy %0b expected 0 0", o_send_valid, o_busy); end
        i_pay_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        start_frame(48'hFFFF_FFFF_FFFF, 16'h0800);
        drive(10, 10, acc);
        wait_idle(ok);
        build_expected(48'hFFFF_FFFF_FFFF, 16'h0800, 10, 1'b0);
        n_vec++; if (!ok || cap.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL rst_after_len: got %0d expected %0d", cap.size(), exp_q.size()); end
        n_vec++; if (first_diff() >= 0) begin n_fail++; $display("[TB] FAIL rst_after_bytes: index %0d got %02h expected %02h", first_diff(), cap[first_diff()], exp_q[first_diff()]); end
    endtask

    task automatic test_back_to_back();
        int acc_a;
        int acc_b;
        int na;
        int nb;
        bit ok;
        na = $urandom_range(30, 60);
        nb = $urandom_range(1, 60);
        fill_random(na);
        start_frame(48'h0A0B_0C0D_0E0F, 16'h1234);
        build_expected(48'h0A0B_0C0D_0E0F, 16'h1234, na, 1'b0);
        drive(na, na, acc_a);
        fill_random(nb);
        i_dst_mac  = 48'h5A5A_5A5A_5A5A;
        i_eth_type = 16'h4321;
        build_expected(48'h5A5A_5A5A_5A5A, 16'h4321, nb, 1'b0);
        drive(nb, nb, acc_b);
        wait_idle(ok);
        n_vec++; if (!ok || acc_a != na || acc_b != nb) begin n_fail++; $display("[TB] FAIL b2b_accept: got %0d/%0d expected %0d/%0d", acc_a, acc_b, na, nb); end
        n_vec++; if (cap.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL b2b_len: got %0d expected %0d", cap.size(), exp_q.size()); end
        n_vec++; if (first_diff() >= 0) begin n_fail++; $display("[TB] FAIL b2b_bytes: index %0d got %02h expected %02h", first_diff(), cap[first_diff()], exp_q[first_diff()]); end
        n_vec++; if (rises != 2) begin n_fail++; $display("[TB] FAIL b2b_runs: got %0d expected 2", rises); end
        n_vec++; if (last_gap != IFG + 1) begin n_fail++; $display("[TB] FAIL b2b_gap: got %0d expected %0d", last_gap, IFG + 1); end
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_crc_unit();
        test_short_frame();
        test_random_frames();
        test_max_frame();
        test_underrun();
        test_oversize();
        test_reset_mid_frame();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Guard against a stalled design
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got no completion expected finish within 2ms");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
